// File: rtl/signed_sat_accumulator_pipe.sv
// Two-stage valid/ready accumulator: stage 1 registers the incoming sample,
// stage 2 adds it into a saturating running sum and holds it for downstream.
module signed_sat_accumulator_pipe #(
   parameter int IN_W  = 4,
   parameter int ACC_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_data,
   output logic                    sat_flag
);

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // One guard bit is enough: |sample| is always smaller than the accumulator range.
   function automatic logic signed [ACC_W:0] widen_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [IN_W-1:0]  b);
      logic signed [ACC_W:0] a_ext;
      logic signed [ACC_W:0] b_ext;
      a_ext = a;
      b_ext = b;
      return a_ext + b_ext;
   endfunction

   function automatic logic is_clamped(input logic signed [ACC_W:0] s);
      return s[ACC_W] != s[ACC_W-1];
   endfunction

   function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] s);
      if (!is_clamped(s))
         return s[ACC_W-1:0];
      else if (s[ACC_W])
         return ACC_MIN;
      else
         return ACC_MAX;
   endfunction

   logic                    vld_p1;
   logic signed [IN_W-1:0]  data_p1;
   logic                    vld_p2;
   logic signed [ACC_W-1:0] acc_p2;
   logic                    sat_p2;

   logic                    adv1;
   logic                    adv2;
   logic                    in_fire;
   logic                    move_p1;
   logic signed [ACC_W:0]   sum_p2;

   assign adv2     = !vld_p2 || out_ready;
   assign adv1     = !vld_p1 || adv2;
   assign in_ready = !clr && adv1;
   assign in_fire  = in_valid && in_ready;
   assign move_p1  = vld_p1 && adv2;
   assign sum_p2   = widen_add(acc_p2, data_p1);

   // Stage 1: input register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else if (clr) begin
         vld_p1  <= 1'b0;
      end else if (in_fire) begin
         vld_p1  <= 1'b1;
         data_p1 <= in_data;
      end else if (move_p1) begin
         vld_p1  <= 1'b0;
      end
   end

   // Stage 2: saturating accumulate and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2 <= 1'b0;
         acc_p2 <= '0;
         sat_p2 <= 1'b0;
      end else if (clr) begin
         vld_p2 <= 1'b0;
         acc_p2 <= '0;
         sat_p2 <= 1'b0;
      end else if (move_p1) begin
         vld_p2 <= 1'b1;
         acc_p2 <= saturate(sum_p2);
         if (is_clamped(sum_p2))
            sat_p2 <= 1'b1;
      end else if (out_ready && vld_p2) begin
         vld_p2 <= 1'b0;
      end
   end

   assign out_valid = vld_p2;
   assign out_data  = acc_p2;
   assign sat_flag  = sat_p2;

endmodule
